// File: rtl/quant_level_pkg.sv
// Shared level/label definitions for the quantified-label writer and drain blocks.
// Level 0 is the low (L) label, level 1 the high (H) label.
package quant_level_pkg;

  typedef enum logic {
    LVL_L = 1'b0,
    LVL_H = 1'b1
  } lvl_t;

  localparam int NUM_LVL = 2;

  function automatic lvl_t other_lvl(input lvl_t lvl);
    return (lvl == LVL_L) ? LVL_H : LVL_L;
  endfunction

endpackage

// File: rtl/quant_level_drain_if.sv
// Partitioned input bus and level-tagged output bus of the drain.
// The slave modport is the drain itself; master is the producer/consumer side.
interface quant_level_drain_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]     in_valid;
  logic [2*W-1:0] in_data;
  logic [1:0]     in_ready;
  logic           out_lvl;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [CW-1:0]  occ_l;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_lvl, out_valid, out_data, occ_l
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_lvl, out_valid, out_data, occ_l
  );

endinterface

// File: rtl/quant_level_fifo.sv
// Single-level word FIFO; one instance per security level so that the
// state of one level never feeds logic belonging to the other.
module quant_level_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/quant_level_drain.sv
// Drains two per-level FIFOs onto one output on a fixed time-slot schedule;
// slot timing never depends on data or handshakes, so H state cannot leak into L.
module quant_level_drain
  import quant_level_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int SLOT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  quant_level_drain_if.slave  bus
);

  localparam int SW = $clog2(SLOT);
  localparam int CW = $clog2(DEPTH + 1);

  logic [SW-1:0] slot_cnt;
  lvl_t          out_lvl_q;

  logic [W-1:0]  head_l, head_h;
  logic [CW-1:0] count_l, count_h;
  logic          full_l, full_h;
  logic          empty_l, empty_h;
  logic          pop_l, pop_h;
  logic          out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt  <= '0;
      out_lvl_q <= LVL_L;
    end else if (slot_cnt == SW'(SLOT - 1)) begin
      slot_cnt  <= '0;
      out_lvl_q <= other_lvl(out_lvl_q);
    end else begin
      slot_cnt  <= slot_cnt + SW'(1);
    end
  end

  assign empty_l = (count_l == '0);
  assign empty_h = (count_h == '0);

  // Only the slot owner may pop; an idle slot is never lent to the other level.
  assign pop_l = (out_lvl_q == LVL_L) && bus.out_ready && !empty_l;
  assign pop_h = (out_lvl_q == LVL_H) && bus.out_ready && !empty_h;

  quant_level_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_l (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.in_valid[0]),
    .push_data (bus.in_data[0 +: W]),
    .pop       (pop_l),
    .head      (head_l),
    .count     (count_l),
    .full      (full_l)
  );

  quant_level_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_h (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.in_valid[1]),
    .push_data (bus.in_data[W +: W]),
    .pop       (pop_h),
    .head      (head_h),
    .count     (count_h),
    .full      (full_h)
  );

  assign out_valid = (out_lvl_q == LVL_H) ? !empty_h : !empty_l;

  always_comb begin
    bus.out_data = '0;
    if (out_valid) bus.out_data = (out_lvl_q == LVL_H) ? head_h : head_l;
  end

  assign bus.out_valid = out_valid;
  assign bus.out_lvl   = out_lvl_q;
  assign bus.in_ready  = {!full_h, !full_l};
  assign bus.occ_l     = count_l;

endmodule
